// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - recovers per-frame PWM duty counts as a signed sample and tracks tone period
module pwm_capture #(
   parameter int N = 8,
   parameter int P = 13
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         fs_clk,
   input  logic         pwm_pos,
   input  logic         pwm_neg,
   output logic [N-1:0] sample_pos,
   output logic [N-1:0] sample_neg,
   output logic [N:0]   sample,
   output logic         sample_valid,
   output logic [P-1:0] period,
   output logic         period_valid,
   output logic         silent
);

   localparam logic [N-1:0] CNT_MAX = '1;
   localparam logic [P-1:0] PCNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, POS, NEG} sign_t;

   logic [1:0]   pos_sync, neg_sync;
   logic         sp, sn;
   logic [N-1:0] cnt_pos, cnt_neg;
   logic         primed;
   logic [P-1:0] pcnt;
   logic         armed;
   sign_t        state, state_next;
   logic         is_pos, is_neg, rising;

   assign sp = pos_sync[1];
   assign sn = neg_sync[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_sync <= '0;
         neg_sync <= '0;
      end else begin
         pos_sync <= {pos_sync[0], pwm_pos};
         neg_sync <= {neg_sync[0], pwm_neg};
      end
   end

   // The strobe cycle itself belongs to the new frame, so the counters load the synced bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_pos      <= '0;
         cnt_neg      <= '0;
         primed       <= 1'b0;
         sample_pos   <= '0;
         sample_neg   <= '0;
         sample       <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= fs_clk & primed;
         if (fs_clk) begin
            cnt_pos <= {{(N-1){1'b0}}, sp};
            cnt_neg <= {{(N-1){1'b0}}, sn};
            primed  <= 1'b1;
            if (primed) begin
               sample_pos <= cnt_pos;
               sample_neg <= cnt_neg;
               sample     <= {1'b0, cnt_pos} - {1'b0, cnt_neg};
            end
         end else begin
            if (sp && cnt_pos != CNT_MAX) cnt_pos <= cnt_pos + 1'b1;
            if (sn && cnt_neg != CNT_MAX) cnt_neg <= cnt_neg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      rising     = 1'b0;
      is_pos     = sample_valid && !sample[N] && (sample != '0);
      is_neg     = sample_valid && sample[N];
      case (state)
         IDLE: begin
            if (is_pos)      state_next = POS;
            else if (is_neg) state_next = NEG;
         end
         POS: if (is_neg) state_next = NEG;
         NEG: begin
            if (is_pos) begin
               state_next = POS;
               rising     = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The first crossing only re-arms; a period is reported from the second crossing on.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt         <= '0;
         armed        <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         silent       <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (sample_valid) begin
            if (rising) begin
               pcnt <= '0;
               if (armed) begin
                  period       <= pcnt + 1'b1;
                  period_valid <= 1'b1;
               end else begin
                  armed  <= 1'b1;
                  silent <= 1'b0;
               end
            end else if (pcnt != PCNT_MAX) begin
               pcnt <= pcnt + 1'b1;
               if (pcnt == PCNT_MAX - 1'b1) begin
                  silent <= 1'b1;
                  armed  <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed table and sequence checks for pwm_capture
module tb_pwm_capture;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic fs_clk = 1'b0;
   logic pwm_pos = 1'b0;
   logic pwm_neg = 1'b0;

   logic [7:0]  sample_pos, sample_neg;
   logic [8:0]  sample;
   logic        sample_valid, period_valid, silent;
   logic [12:0] period;

   logic [5:0]  sample_pos6, sample_neg6;
   logic [6:0]  sample6;
   logic        sample_valid6, period_valid6, silent6;
   logic [12:0] period6;

   pwm_capture #(.N(8), .P(13)) dut (
      .clk(clk), .reset(reset), .fs_clk(fs_clk), .pwm_pos(pwm_pos), .pwm_neg(pwm_neg),
      .sample_pos(sample_pos), .sample_neg(sample_neg), .sample(sample),
      .sample_valid(sample_valid), .period(period), .period_valid(period_valid),
      .silent(silent)
   );

   pwm_capture #(.N(6), .P(13)) dut6 (
      .clk(clk), .reset(reset), .fs_clk(fs_clk), .pwm_pos(pwm_pos), .pwm_neg(pwm_neg),
      .sample_pos(sample_pos6), .sample_neg(sample_neg6), .sample(sample6),
      .sample_valid(sample_valid6), .period(period6), .period_valid(period_valid6),
      .silent(silent6)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int sv_cnt = 0, sv6_cnt = 0, pv_cnt = 0, overlap = 0, late = 0;
   int pv_last = 0, pv_prev = 0, sil_at = -1;
   int c_p8 = 0, c_n8 = 0, c_s8 = 0, c_p6 = 0, c_n6 = 0, c_s6 = 0, c_per = 0, c_per6 = 0;
   logic last_sv = 1'b0, last_sil = 1'b0;

   always @(negedge clk) begin
      if (sample_valid) begin
         sv_cnt <= sv_cnt + 1;
         c_p8   <= int'(sample_pos);
         c_n8   <= int'(sample_neg);
         c_s8   <= int'($signed(sample));
      end
      if (sample_valid6) begin
         sv6_cnt <= sv6_cnt + 1;
         c_p6    <= int'(sample_pos6);
         c_n6    <= int'(sample_neg6);
         c_s6    <= int'($signed(sample6));
      end
      if (period_valid) begin
         pv_cnt  <= pv_cnt + 1;
         c_per   <= int'(period);
         pv_prev <= pv_last;
         pv_last <= sv_cnt;
         if (sample_valid) overlap <= overlap + 1;
         if (!last_sv)     late <= late + 1;
      end
      if (period_valid6) c_per6 <= int'(period6);
      if (silent && !last_sil) sil_at <= sv_cnt;
      last_sv  <= sample_valid;
      last_sil <= silent;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic run_frame(input int dp, input int dn, input int len);
      for (int c = 0; c < len; c++) begin
         @(posedge clk);
         #1;
         fs_clk  = (c == 0);
         pwm_pos = (c < dp);
         pwm_neg = (c < dn);
      end
   endtask

   task automatic wave(input int cycles, input int len);
      for (int k = 0; k < cycles; k++) begin
         for (int f = 0; f < 10; f++) run_frame(30, 0, len);
         for (int f = 0; f < 10; f++) run_frame(0, 30, len);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      reset   = 1'b1;
      fs_clk  = 1'b0;
      pwm_pos = 1'b0;
      pwm_neg = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      int dp; int dn; int len;
      int p8; int n8; int s8;
      int p6; int n6; int s6;
   } vec_t;

   vec_t tbl[10];
   int base_sv, base_pv;

   initial begin
      tbl[0] = '{40,   0, 125,  40,   0,   40, 40,  0,  40};
      tbl[1] = '{40,   0, 125,  40,   0,   40, 40,  0,  40};
      tbl[2] = '{ 0,  30, 125,   0,  30,  -30,  0, 30, -30};
      tbl[3] = '{50,  50, 125,  50,  50,    0, 50, 50,   0};
      tbl[4] = '{ 0, 125, 125,   0, 123, -123,  0, 63, -63};
      tbl[5] = '{ 0, 125, 125,   0, 125, -125,  0, 63, -63};
      tbl[6] = '{ 0,   0, 125,   0,   2,   -2,  0,  2,  -2};
      tbl[7] = '{ 1,   0,   3,   1,   0,    1,  1,  0,   1};
      tbl[8] = '{298,  0, 300, 255,   0,  255, 63,  0,  63};
      tbl[9] = '{ 0,   0,   4,   0,   0,    0,  0,  0,   0};

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Each row's sample emerges one strobe later, so row i is checked after row i+1 runs.
      for (int i = 0; i <= 10; i++) begin
         base_sv = sv_cnt;
         if (i < 10) run_frame(tbl[i].dp, tbl[i].dn, tbl[i].len);
         else        run_frame(0, 0, 10);
         chk($sformatf("valid_pulses_row%0d", i), sv_cnt - base_sv, (i == 0) ? 0 : 1);
         if (i > 0) begin
            chk($sformatf("pos8_row%0d", i-1), c_p8, tbl[i-1].p8);
            chk($sformatf("neg8_row%0d", i-1), c_n8, tbl[i-1].n8);
            chk($sformatf("smp8_row%0d", i-1), c_s8, tbl[i-1].s8);
            chk($sformatf("pos6_row%0d", i-1), c_p6, tbl[i-1].p6);
            chk($sformatf("neg6_row%0d", i-1), c_n6, tbl[i-1].n6);
            chk($sformatf("smp6_row%0d", i-1), c_s6, tbl[i-1].s6);
         end
      end
      chk("table_no_period", pv_cnt, 0);
      chk("table_valid6_count", sv6_cnt, sv_cnt);

      do_reset();
      base_pv = pv_cnt;
      base_sv = sv_cnt;
      run_frame(30, 0, 40);
      chk("prime_no_valid", sv_cnt - base_sv, 0);
      run_frame(30, 0, 40);
      chk("second_strobe_one_valid", sv_cnt - base_sv, 1);
      for (int f = 0; f < 8; f++) run_frame(30, 0, 40);
      for (int f = 0; f < 10; f++) run_frame(0, 30, 40);
      wave(1, 40);
      chk("first_crossing_no_pulse", pv_cnt - base_pv, 0);
      wave(1, 40);
      chk("period_pulses_3", pv_cnt - base_pv, 1);
      chk("period_3", c_per, 20);
      wave(1, 40);
      chk("period_pulses_4", pv_cnt - base_pv, 2);
      chk("period_4", c_per, 20);
      chk("period_spacing", pv_last - pv_prev, 20);
      chk("period6_4", c_per6, 20);
      chk("not_silent", int'(silent), 0);

      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("rst_sample_pos", int'(sample_pos), 0);
      chk("rst_sample_neg", int'(sample_neg), 0);
      chk("rst_sample", int'(sample), 0);
      chk("rst_sample_valid", int'(sample_valid), 0);
      chk("rst_period", int'(period), 0);
      chk("rst_period_valid", int'(period_valid), 0);
      chk("rst_silent", int'(silent), 0);
      fs_clk  = 1'b0;
      pwm_pos = 1'b0;
      pwm_neg = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      base_sv = sv_cnt;
      base_pv = pv_cnt;
      for (int f = 0; f < 8201; f++) run_frame(0, 0, 4);
      chk("silent_after_8191", sil_at - base_sv, 8191);
      chk("silent_high", int'(silent), 1);
      chk("silence_no_period", pv_cnt - base_pv, 0);

      wave(1, 40);
      chk("silent_held", int'(silent), 1);
      run_frame(30, 0, 40);
      run_frame(30, 0, 40);
      chk("silent_cleared", int'(silent), 0);
      chk("recover_no_pulse", pv_cnt - base_pv, 0);
      for (int f = 0; f < 8; f++) run_frame(30, 0, 40);
      for (int f = 0; f < 10; f++) run_frame(0, 30, 40);
      run_frame(30, 0, 40);
      run_frame(30, 0, 40);
      chk("recover_period_pulse", pv_cnt - base_pv, 1);
      chk("recover_period", c_per, 20);
      for (int f = 0; f < 8; f++) run_frame(30, 0, 40);

      base_pv = pv_cnt;
      for (int f = 0; f < 5; f++) run_frame(50, 50, 60);
      chk("equal_sample", c_s8, 0);
      chk("equal_pos", c_p8, 50);
      chk("equal_no_period", pv_cnt - base_pv, 0);
      for (int f = 0; f < 10; f++) run_frame(0, 30, 40);
      run_frame(30, 0, 40);
      run_frame(30, 0, 40);
      chk("after_equal_pulse", pv_cnt - base_pv, 1);
      chk("after_equal_period", c_per, 25);

      chk("pv_sv_overlap", overlap, 0);
      chk("pv_latency", late, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
